cpu_run_monitor: RTL
====================

Name: cpu_run_monitor

Overview:
Synthesisable run controller and result checker for CPU_Core program tests. It replaces a fixed "reset, run N cycles, stop" sequence with a parametrised one. It sequences the core reset, then snoops the DMEM write bus for a halt store to a magic address or a cycle timeout. A checksum of all stores into a result window is compared against an expected value to produce pass/fail. It sits beside CPU_Core/RAM in program-level benches and FPGA smoke tests.

Parameters:
ADDR_W, 10, DMEM word-address width (matches address_DMEM)
DATA_W, 32, DMEM data width
RST_CYCLES, 1, cycles core_RSTn is held low after start (>=1)
MAX_CYCLES, 3000, RUN-cycle budget before timeout (>=1)
HALT_ADDR, 1023, store to this address ends the run
RES_BASE, 16, first word address of result window
NUM_RES, 8, result window length in words; RES_BASE+NUM_RES <= 2**ADDR_W, else elaboration error
EXP_SUM, 0, expected checksum (sum mod 2**DATA_W of window stores)

Ports:
CLK  in  1  clock, all state on rising edge
RSTn  in  1  asynchronous active-low reset
start  in  1  begin/restart a run (sampled in IDLE and DONE only)
MemWrite  in  1  snooped DMEM write enable
address_DMEM  in  ADDR_W  snooped DMEM address
write_data_DMEM  in  DATA_W  snooped DMEM write data
core_RSTn  out  1  active-low reset to CPU_Core, registered
busy  out  1  high in RESET and RUN
done  out  1  high in DONE
halted  out  1  run ended by halt store
timeout  out  1  run ended by cycle budget
pass  out  1  result verdict, valid when done
cycle_count  out  clog2(MAX_CYCLES+1)  RUN cycles elapsed
store_count  out  clog2(NUM_RES+2)  window stores, saturating
checksum  out  DATA_W  running sum of window store data

Behaviour:
- States: IDLE, RESET, RUN, DONE. RSTn low (async) -> IDLE; all outputs 0, including core_RSTn=0 (core held in reset), counters 0.
- IDLE: core_RSTn=0. start=1 -> RESET next edge. Clear cycle_count, store_count, checksum, halted, timeout, pass.
- RESET: core_RSTn=0 for exactly RST_CYCLES cycles (internal counter), then RUN. core_RSTn=1 from the first RUN cycle.
- RUN: core_RSTn=1. Each cycle cycle_count+=1 (its value after the edge = RUN cycles completed). start is ignored.
- Halt: MemWrite=1 && address_DMEM==HALT_ADDR -> halted=1, DONE next edge; this store is never counted or summed, even if inside the window.
- Window store: MemWrite=1 && RES_BASE <= address_DMEM < RES_BASE+NUM_RES (unsigned, no wrap) -> checksum += write_data_DMEM mod 2**DATA_W; store_count+=1, saturating at NUM_RES+1. Stores outside the window are ignored.
- Timeout: in the RUN cycle where cycle_count becomes MAX_CYCLES with no halt that cycle -> timeout=1, DONE. A halt in that same cycle wins: halted=1, timeout=0.
- On the DONE entry edge, register pass = halted && store_count==NUM_RES && checksum==EXP_SUM, using values that include that cycle's updates.
- DONE: core_RSTn=0 (freezes core); all results held stable. start=1 -> RESET (counters cleared as in IDLE).
- halted and timeout are mutually exclusive. pass=1 implies halted=1.
- RSTn low in any state, including mid-RUN: immediate IDLE, core_RSTn=0 without waiting for a clock edge, results cleared.

Test Plan:
Use a bus stub in place of CPU_Core. Parameters: RES_BASE=16, NUM_RES=4, HALT_ADDR=1023, EXP_SUM=11, MAX_CYCLES=50, RST_CYCLES=2.
- start pulse -> core_RSTn low exactly 2 cycles, then 1. Stub writes 1,2,3,5 to addresses 16..19 on RUN cycles 3..6, then addr 1023 on cycle 10 -> done, halted=1, checksum=11, store_count=4, cycle_count=10, pass=1.
- No halt store -> timeout=1 and done after cycle_count=50, halted=0, pass=0, core_RSTn=0.
- Halt store on RUN cycle 50 -> halted=1, timeout=0, cycle_count=50.
- Extra stores to addresses 15 and 20 (data 100), plus a fifth window store of data 0 -> checksum=11, store_count=5, pass=0. Stores to 15/20 must not change checksum.
- RSTn low mid-RUN at cycle 7 -> core_RSTn=0 and all outputs 0 before the next edge; state IDLE.
- start during RUN is ignored. start in DONE -> RESET with counters cleared; a second identical run gives pass=1 again.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Run controller and result checker for CPU_Core program tests: sequences the core reset,
// snoops DMEM stores for a halt or a cycle budget, and checksums a result window.
module cpu_run_monitor #(
    parameter int                 ADDR_W     = 10,
    parameter int                 DATA_W     = 32,
    parameter int                 RST_CYCLES = 1,
    parameter int                 MAX_CYCLES = 3000,
    parameter int                 HALT_ADDR  = 1023,
    parameter int                 RES_BASE   = 16,
    parameter int                 NUM_RES    = 8,
    parameter logic [DATA_W-1:0]  EXP_SUM    = {DATA_W{1'b0}}
) (
    input  logic                                CLK,
    input  logic                                RSTn,
    input  logic                                start,
    input  logic                                MemWrite,
    input  logic [ADDR_W-1:0]                   address_DMEM,
    input  logic [DATA_W-1:0]                   write_data_DMEM,
    output logic                                core_RSTn,
    output logic                                busy,
    output logic                                done,
    output logic                                halted,
    output logic                                timeout,
    output logic                                pass,
    output logic [$clog2(MAX_CYCLES+1)-1:0]     cycle_count,
    output logic [$clog2(NUM_RES+2)-1:0]        store_count,
    output logic [DATA_W-1:0]                   checksum
);

    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int SW = $clog2(NUM_RES + 2);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [CW-1:0]     CYC_LAST  = CW'(MAX_CYCLES - 1);
    localparam logic [SW-1:0]     STORE_SAT = SW'(NUM_RES + 1);
    localparam logic [SW-1:0]     STORE_EXP = SW'(NUM_RES);
    localparam logic [RW-1:0]     RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [ADDR_W-1:0] HALT_A    = ADDR_W'(HALT_ADDR);
    // One extra bit so a window ending exactly at 2**ADDR_W does not wrap.
    localparam logic [ADDR_W:0]   WIN_LO    = (ADDR_W+1)'(RES_BASE);
    localparam logic [ADDR_W:0]   WIN_HI    = (ADDR_W+1)'(RES_BASE + NUM_RES);

    if (RES_BASE + NUM_RES > (1 << ADDR_W)) begin : g_bad_window
        $error("cpu_run_monitor: result window exceeds the DMEM address space");
    end
    if (RST_CYCLES < 1 || MAX_CYCLES < 1) begin : g_bad_counts
        $error("cpu_run_monitor: RST_CYCLES and MAX_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [RW-1:0]       r_rst_cnt, w_rst_cnt_nxt;
    logic [CW-1:0]       r_cycle, w_cycle_nxt;
    logic [SW-1:0]       r_store, w_store_nxt;
    logic [DATA_W-1:0]   r_sum, w_sum_nxt;
    logic                r_halted, w_halted_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic                r_pass, w_pass_nxt;
    logic                r_core_rstn, r_busy, r_done;
    logic                w_halt, w_win;

    // Next-state and result-update logic; halt stores are excluded from the window.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_cycle_nxt   = r_cycle;
        w_store_nxt   = r_store;
        w_sum_nxt     = r_sum;
        w_halted_nxt  = r_halted;
        w_timeout_nxt = r_timeout;
        w_pass_nxt    = r_pass;
        w_halt        = MemWrite && (address_DMEM == HALT_A);
        w_win         = MemWrite && !w_halt &&
                        ({1'b0, address_DMEM} >= WIN_LO) && ({1'b0, address_DMEM} < WIN_HI);
        case (r_state)
            S_IDLE: begin
                w_rst_cnt_nxt = {RW{1'b0}};
                w_cycle_nxt   = {CW{1'b0}};
                w_store_nxt   = {SW{1'b0}};
                w_sum_nxt     = {DATA_W{1'b0}};
                w_halted_nxt  = 1'b0;
                w_timeout_nxt = 1'b0;
                w_pass_nxt    = 1'b0;
                if (start) begin
                    w_state_nxt = S_RESET;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESET: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_rst_cnt_nxt = {RW{1'b0}};
                    w_state_nxt   = S_RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + RW'(1);
                    w_state_nxt   = S_RESET;
                end
            end
            S_RUN: begin
                w_cycle_nxt = r_cycle + CW'(1);
                if (w_win) begin
                    w_sum_nxt = r_sum + write_data_DMEM;
                    if (r_store != STORE_SAT) begin
                        w_store_nxt = r_store + SW'(1);
                    end else begin
                        w_store_nxt = r_store;
                    end
                end else begin
                    w_sum_nxt   = r_sum;
                    w_store_nxt = r_store;
                end
                if (w_halt) begin
                    w_halted_nxt = 1'b1;
                    w_pass_nxt   = (w_store_nxt == STORE_EXP) && (w_sum_nxt == EXP_SUM);
                    w_state_nxt  = S_DONE;
                end else if (r_cycle == CYC_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_pass_nxt    = 1'b0;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_rst_cnt_nxt = {RW{1'b0}};
                    w_cycle_nxt   = {CW{1'b0}};
                    w_store_nxt   = {SW{1'b0}};
                    w_sum_nxt     = {DATA_W{1'b0}};
                    w_halted_nxt  = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_pass_nxt    = 1'b0;
                    w_state_nxt   = S_RESET;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, result and registered status outputs; core reset tracks the next state.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_rst_cnt   <= {RW{1'b0}};
            r_cycle     <= {CW{1'b0}};
            r_store     <= {SW{1'b0}};
            r_sum       <= {DATA_W{1'b0}};
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
            r_pass      <= 1'b0;
            r_core_rstn <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_cycle     <= w_cycle_nxt;
            r_store     <= w_store_nxt;
            r_sum       <= w_sum_nxt;
            r_halted    <= w_halted_nxt;
            r_timeout   <= w_timeout_nxt;
            r_pass      <= w_pass_nxt;
            r_core_rstn <= (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt == S_RESET) || (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign core_RSTn   = r_core_rstn;
    assign busy        = r_busy;
    assign done        = r_done;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign pass        = r_pass;
    assign cycle_count = r_cycle;
    assign store_count = r_store;
    assign checksum    = r_sum;

endmodule
